// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: timing defaults, writer state encoding and
// frame helpers, common to the PS/2 writer and reader.
package ps2_pkg;

  localparam logic [12:0] T100US_DEF  = 13'd5000;
  localparam logic [19:0] TIMEOUT_DEF = 20'd750000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RELEASE,
    ST_SEND,
    ST_ACK,
    ST_WAITIDLE,
    ST_DONE
  } wr_state_e;

  // Bit idx of the host frame after the start bit: data[0..7], parity, stop.
  function automatic logic frame_bit(
    input logic [7:0] b,
    input logic       par,
    input logic [3:0] idx
  );
    logic v;
    v = 1'b1;
    if (idx < 4'd8) begin
      v = b[idx[2:0]];
    end else if (idx == 4'd8) begin
      v = par;
    end
    return v;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for one PS/2 line with falling-edge detect.
// Shared between the PS/2 writer and reader.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [1:0] f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f <= 2'b11;
    end else begin
      f <= {f[0], pin};
    end
  end

  assign level = f[1];
  assign fall  = f[1] & ~f[0];

endmodule

// File: rtl/ps2_write_funcmod.sv
// PS/2 host-to-device byte writer: clock inhibit, start bit, 8 data bits,
// odd parity, stop, device ACK, with a per-wait timeout.
module ps2_write_funcmod
  import ps2_pkg::*;
#(
  parameter logic [12:0] T100US  = T100US_DEF,
  parameter logic [19:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic       CLOCK,
  input  logic       RESET,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  input  logic       iEn,
  input  logic [7:0] iData,
  output logic       oTrig,
  output logic       oAck
);

  localparam logic [12:0] INH_LAST = T100US - 13'd1;
  localparam logic [19:0] TO_LAST  = TIMEOUT - 20'd1;

  wr_state_e   state, state_n;
  logic [12:0] cnt, cnt_n;
  logic [19:0] tcnt, tcnt_n;
  logic [3:0]  bits, bits_n;
  logic [7:0]  byte_q, byte_n;
  logic        par, par_n;
  logic        ack_pend, ack_pend_n;
  logic        ack_q, ack_n;
  logic        clk_low, clk_low_n;
  logic        dat_low, dat_low_n;

  logic clk_lvl, clk_fall;
  logic dat_lvl, unused_dat_fall;
  logic tout;

  ps2_sync u_clk_sync (
    .clk   (CLOCK),
    .rst   (RESET),
    .pin   (PS2_CLK),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_sync u_dat_sync (
    .clk   (CLOCK),
    .rst   (RESET),
    .pin   (PS2_DAT),
    .level (dat_lvl),
    .fall  (unused_dat_fall)
  );

  // Counted from entry to SEND and from every device falling edge.
  assign tout = (tcnt == TO_LAST);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tcnt_n     = tcnt;
    bits_n     = bits;
    byte_n     = byte_q;
    par_n      = par;
    ack_pend_n = ack_pend;
    ack_n      = ack_q;
    clk_low_n  = clk_low;
    dat_low_n  = dat_low;
    unique case (state)
      ST_IDLE: begin
        clk_low_n = 1'b0;
        dat_low_n = 1'b0;
        if (iEn) begin
          byte_n     = iData;
          par_n      = ~^iData;
          bits_n     = '0;
          cnt_n      = '0;
          ack_pend_n = 1'b0;
          clk_low_n  = 1'b1;
          dat_low_n  = (INH_LAST == '0);
          state_n    = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        cnt_n     = cnt + 13'd1;
        dat_low_n = (cnt_n == INH_LAST);
        if (cnt == INH_LAST) begin
          cnt_n     = '0;
          clk_low_n = 1'b0;
          dat_low_n = 1'b1;
          state_n   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        tcnt_n  = '0;
        state_n = ST_SEND;
      end
      ST_SEND: begin
        tcnt_n = tcnt + 20'd1;
        if (clk_fall) begin
          tcnt_n = '0;
          bits_n = bits + 4'd1;
          if (bits == 4'd9) begin
            dat_low_n = 1'b0;
            state_n   = ST_ACK;
          end else begin
            dat_low_n = ~frame_bit(byte_q, par, bits);
          end
        end else if (tout) begin
          clk_low_n = 1'b0;
          dat_low_n = 1'b0;
          ack_n     = 1'b0;
          state_n   = ST_DONE;
        end
      end
      ST_ACK: begin
        tcnt_n = tcnt + 20'd1;
        if (clk_fall) begin
          tcnt_n     = '0;
          ack_pend_n = ~dat_lvl;
          state_n    = ST_WAITIDLE;
        end else if (tout) begin
          clk_low_n = 1'b0;
          dat_low_n = 1'b0;
          ack_n     = 1'b0;
          state_n   = ST_DONE;
        end
      end
      ST_WAITIDLE: begin
        tcnt_n = tcnt + 20'd1;
        if (clk_lvl && dat_lvl) begin
          ack_n   = ack_pend;
          state_n = ST_DONE;
        end else if (clk_fall) begin
          tcnt_n = '0;
        end else if (tout) begin
          clk_low_n = 1'b0;
          dat_low_n = 1'b0;
          ack_n     = 1'b0;
          state_n   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      tcnt     <= '0;
      bits     <= '0;
      byte_q   <= '0;
      par      <= 1'b0;
      ack_pend <= 1'b0;
      ack_q    <= 1'b0;
      clk_low  <= 1'b0;
      dat_low  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tcnt     <= tcnt_n;
      bits     <= bits_n;
      byte_q   <= byte_n;
      par      <= par_n;
      ack_pend <= ack_pend_n;
      ack_q    <= ack_n;
      clk_low  <= clk_low_n;
      dat_low  <= dat_low_n;
    end
  end

  // Open-drain: only ever pull low or float.
  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

  assign oTrig = (state == ST_DONE);
  assign oAck  = ack_q;

endmodule
